mod_exp_engine: RTL
===================

MOD_EXP_ENGINE -- requirements
Module: mod_exp_engine

Interface
REQ-001 Parameter WIDTH, default 64: bit width of base, modulus and result.
REQ-002 Parameter EXP_WIDTH, default 64: bit width of exponent.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 base  input  WIDTH  base B; any value, may be >= modulus.
REQ-007 exponent  input  EXP_WIDTH  exponent E.
REQ-008 modulus  input  WIDTH  modulus M.
REQ-009 result  output  WIDTH  B^E mod M; held stable from done until next accepted start.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 error  output  1  high with done when M==0; held until next accepted start.

Function
REQ-013 States: IDLE, REDUCE, INIT, TEST, MUL, SQR, DONE.
REQ-014 IDLE & start: latch B, E, M; clear error; go to REDUCE.
- Exception: M==0 goes to DONE with result=0 and error=1.
- Exception: M==1 goes to DONE with result=0 and error=0.
REQ-015 start outside IDLE is ignored; inputs may change freely after acceptance.
REQ-016 REDUCE: b = mulmod(B,1), giving B mod M; lasts exactly WIDTH cycles.
REQ-017 INIT: r=1, e=E; 1 cycle; then TEST.
REQ-018 TEST (1 cycle):
- e[0]==1: go to MUL.
- e[0]==0 and (e>>1)!=0: go to SQR.
- otherwise: go to DONE.
REQ-019 MUL: r = mulmod(r,b); WIDTH cycles; then SQR if (e>>1)!=0, else DONE.
REQ-020 SQR: b = mulmod(b,b), e = e>>1; WIDTH cycles; then TEST.
REQ-021 DONE: result<=r, done=1 for exactly 1 cycle; next state IDLE; back-to-back start accepted the cycle after DONE.
REQ-022 Latency, start-accept edge = cycle 0, normal path: done high in cycle N = WIDTH + 2 + (s+1) + WIDTH*(k+s).
- k = popcount(E); s = index of E's MSB set (s=0 when E==0).
- Special-M path: N = 1.
REQ-023 mulmod(A,Bm): interleaved Blakley algorithm, MSB of A first.
- Per cycle: P = 2P + a_i*Bm, then subtract M up to twice so that P < M.
- Precondition: Bm < M.
- Internal sum width: WIDTH+2; no truncation.
REQ-024 E==0 yields result=1 (M>=2); B mod M==0 with E>0 yields result=0.

Reset
REQ-025 reset forces IDLE in the same edge, overriding any state including mid-multiply.
REQ-026 On reset: result=0, done=0, busy=0, error=0; multiplier accumulator and counter cleared.
REQ-027 start coincident with reset is ignored.

Structure
REQ-028 Shared package mod_arith_pkg holds:
- the state encoding constants;
- default WIDTH/EXP_WIDTH;
- the Blakley step count constant.
REQ-029 One sub-module mod_mul (WIDTH parameter) has start/done handshake, a WIDTH-cycle latency and the same clk/reset.
- The engine instantiates it once and time-shares it across REDUCE, MUL and SQR.

Verification
REQ-030 WIDTH=64: B=2, E=96, M=485 -> result=1, error=0, done pulses exactly once.
REQ-031 WIDTH=64: B=2, E=12, M=87 -> result=7; B=3, E=13, M=311 -> result=137; run back-to-back with start held high.
REQ-032 WIDTH=64: B=500, E=3, M=485 (base >= modulus) -> result=465.
REQ-033 Boundaries:
- M=0 -> done at cycle 1 with error=1, result=0.
- M=1 -> result=0, error=0.
- E=0, M=97 -> result=1, done at cycle WIDTH+3.
REQ-034 WIDTH=16, EXP_WIDTH=8: B=3, E=13, M=311 -> result=137, done at cycle N=16+2+4+16*6=118.
- Then a reset pulse in SQR -> next cycle busy=0, done=0.
- Then a new request completes correctly.

Source files
------------

// File: rtl/mod_arith_pkg.sv
// Shared definitions for the modular exponentiation engine and its Blakley multiplier.
// Holds the FSM encoding, default operand widths and the multiplier step count.
package mod_arith_pkg;

  localparam int DEF_WIDTH     = 64;
  localparam int DEF_EXP_WIDTH = 64;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REDUCE = 3'd1,
    S_INIT   = 3'd2,
    S_TEST   = 3'd3,
    S_MUL    = 3'd4,
    S_SQR    = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  // One Blakley step consumes one bit of the multiplier operand.
  function automatic int blakley_steps(input int width);
    return width;
  endfunction

endpackage

// File: rtl/mod_mul.sv
// Interleaved Blakley modular multiplier: p = a * b mod m, MSB of a first.
// A start pulse performs the first step; done is raised in the last of WIDTH busy cycles.
module mod_mul
  import mod_arith_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_m,
  output logic             o_done,
  output logic [WIDTH-1:0] o_p
);

  localparam int STEPS = blakley_steps(WIDTH);
  localparam int CNT_W = $clog2(STEPS + 1);

  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_p;

  logic             w_bit;
  logic [WIDTH-1:0] w_p_in;
  logic [WIDTH-1:0] w_b_in;
  logic [WIDTH+1:0] w_m_ext;
  logic [WIDTH+1:0] w_sum;
  logic [WIDTH+1:0] w_sub1;
  logic [WIDTH-1:0] w_p_next;

  // The start cycle works straight from the inputs so the product is ready after WIDTH cycles.
  always_comb begin
    w_bit    = i_start ? i_a[WIDTH-1] : r_a[WIDTH-1];
    w_p_in   = i_start ? '0 : r_p;
    w_b_in   = i_start ? i_b : r_b;
    w_m_ext  = {2'b00, (i_start ? i_m : r_m)};
    w_sum    = {1'b0, w_p_in, 1'b0} + (w_bit ? {2'b00, w_b_in} : '0);
    w_sub1   = (w_sum >= w_m_ext) ? w_sum - w_m_ext : w_sum;
    w_p_next = (w_sub1 >= w_m_ext) ? WIDTH'(w_sub1 - w_m_ext) : WIDTH'(w_sub1);
  end

  assign o_done = r_busy && (r_cnt == CNT_W'(STEPS - 1));
  assign o_p    = w_p_next;

  // NOTE: registers use non-blocking assignments so every one samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_m    <= '0;
      r_p    <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= CNT_W'(1);
      r_a    <= i_a << 1;
      r_b    <= i_b;
      r_m    <= i_m;
      r_p    <= w_p_next;
    end else if (r_busy) begin
      r_p   <= w_p_next;
      r_a   <= r_a << 1;
      r_cnt <= r_cnt + CNT_W'(1);
      if (o_done) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/mod_exp_engine.sv
// Right-to-left square-and-multiply modular exponentiation: result = base^exponent mod modulus.
// A single Blakley multiplier is time-shared by the REDUCE, MUL and SQR phases.
module mod_exp_engine
  import mod_arith_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int EXP_WIDTH = DEF_EXP_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0]     modulus,
  output logic [WIDTH-1:0]     result,
  output logic                 done,
  output logic                 busy,
  output logic                 error
);

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH-1:0]     r_base;
  logic [WIDTH-1:0]     r_b;
  logic [WIDTH-1:0]     r_acc;
  logic [WIDTH-1:0]     r_mod;
  logic [WIDTH-1:0]     r_result;
  logic [EXP_WIDTH-1:0] r_e;
  logic                 r_error;
  logic                 r_mul_start;

  logic                 w_special;
  logic                 w_e_more;
  logic                 w_mul_done;
  logic [WIDTH-1:0]     w_mul_a;
  logic [WIDTH-1:0]     w_mul_b;
  logic [WIDTH-1:0]     w_mul_p;

  // Moduli 0 and 1 need no arithmetic: the answer is 0 either way.
  assign w_special = (modulus <= WIDTH'(1));
  assign w_e_more  = ((r_e >> 1) != '0);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_mul_a      = r_base;
    w_mul_b      = WIDTH'(1);
    done         = 1'b0;
    busy         = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:   if (start) w_state_next = w_special ? S_DONE : S_REDUCE;
      S_REDUCE: if (w_mul_done) w_state_next = S_INIT;
      S_INIT:   w_state_next = S_TEST;
      S_TEST: begin
        if (r_e[0])        w_state_next = S_MUL;
        else if (w_e_more) w_state_next = S_SQR;
        else               w_state_next = S_DONE;
      end
      S_MUL: begin
        w_mul_a = r_acc;
        w_mul_b = r_b;
        if (w_mul_done) w_state_next = w_e_more ? S_SQR : S_DONE;
      end
      S_SQR: begin
        w_mul_a = r_b;
        w_mul_b = r_b;
        if (w_mul_done) w_state_next = S_TEST;
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_base      <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_mod       <= '0;
      r_result    <= '0;
      r_e         <= '0;
      r_error     <= 1'b0;
      r_mul_start <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_mul_start <= (w_state_next != r_state) &&
                     (w_state_next inside {S_REDUCE, S_MUL, S_SQR});
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_base  <= base;
            r_e     <= exponent;
            r_mod   <= modulus;
            r_error <= (modulus == '0);
            if (w_special) r_result <= '0;
          end
        end
        S_REDUCE: if (w_mul_done) r_b <= w_mul_p;
        S_INIT:   r_acc <= WIDTH'(1);
        S_TEST:   if (w_state_next == S_DONE) r_result <= r_acc;
        S_MUL: begin
          if (w_mul_done) begin
            r_acc <= w_mul_p;
            if (!w_e_more) r_result <= w_mul_p;
          end
        end
        S_SQR: begin
          if (w_mul_done) begin
            r_b <= w_mul_p;
            r_e <= r_e >> 1;
          end
        end
        default: ;
      endcase
    end
  end

  mod_mul #(
    .WIDTH(WIDTH)
  ) u_mod_mul (
    .clk    (clk),
    .reset  (reset),
    .i_start(r_mul_start),
    .i_a    (w_mul_a),
    .i_b    (w_mul_b),
    .i_m    (r_mod),
    .o_done (w_mul_done),
    .o_p    (w_mul_p)
  );

  assign result = r_result;
  assign error  = r_error;

endmodule
